// File: rtl/traffic_light_uart_rx.sv
// UART 8N1 receiver that assembles space-terminated words and decodes them
// into a traffic-light code (Green/Yellow/Red/Pedestrian).
module traffic_light_uart_rx #(
  parameter int CLKS_PER_BIT = 105,
  parameter int MAX_WORD     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [1:0] light_state,
  output logic       state_valid,
  output logic       state_known,
  output logic       frame_err,
  output logic       word_err,
  output logic [1:0] dbg_state
);

  // All *_valid / *_err outputs are single-cycle strobes with no back-pressure:
  // the associated data is stable in the same cycle the strobe is high.

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = $clog2(MAX_WORD + 1);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            stop_err_q, stop_err_d;
  logic            load_byte, ferr_set;
  logic            half_hit, full_hit;

  logic [7:0]      byte_data_q;
  logic            byte_valid_q, frame_err_q;

  logic [79:0]     buf_q;
  logic [LW-1:0]   len_q;
  logic            discard_q;
  logic [1:0]      light_q;
  logic            state_valid_q, state_known_q, word_err_q;
  logic            is_space, match;
  logic [1:0]      match_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign half_hit = (timer_q == HALF_T);
  assign full_hit = (timer_q == LAST_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full_hit && bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP: begin
        if (stop_err_q) begin
          if (rx_s) state_d = S_IDLE;
        end else if (full_hit && rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d    = timer_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_err_d = stop_err_q;
    load_byte  = 1'b0;
    ferr_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d    = '0;
        bit_cnt_d  = '0;
        stop_err_d = 1'b0;
      end
      S_START: timer_d = half_hit ? '0 : timer_q + TW'(1);
      S_DATA: begin
        timer_d = full_hit ? '0 : timer_q + TW'(1);
        if (full_hit) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (stop_err_q) begin
          // Broken stop bit: park until the line returns to idle.
          timer_d = '0;
          if (rx_s) stop_err_d = 1'b0;
        end else begin
          timer_d = full_hit ? '0 : timer_q + TW'(1);
          if (full_hit) begin
            if (rx_s) begin
              load_byte = 1'b1;
            end else begin
              ferr_set   = 1'b1;
              stop_err_d = 1'b1;
            end
          end
        end
      end
      default: timer_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q      <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_err_q   <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_err_q   <= stop_err_d;
      byte_valid_q <= load_byte;
      frame_err_q  <= ferr_set;
      if (load_byte) byte_data_q <= shift_q;
    end
  end

  // The buffer keeps the newest characters in its low bytes, so a word of
  // length N is matched against buf_q[8*N-1:0].
  always_comb begin
    match      = 1'b1;
    match_code = 2'b10;
    if (int'(len_q) == 5 && buf_q[39:0] == "Green")            match_code = 2'b00;
    else if (int'(len_q) == 6 && buf_q[47:0] == "Yellow")      match_code = 2'b01;
    else if (int'(len_q) == 3 && buf_q[23:0] == "Red")         match_code = 2'b10;
    else if (int'(len_q) == 10 && buf_q[79:0] == "Pedestrian") match_code = 2'b11;
    else match = 1'b0;
  end

  assign is_space = (byte_data_q == 8'h20);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q         <= '0;
      len_q         <= '0;
      discard_q     <= 1'b0;
      light_q       <= 2'b10;
      state_valid_q <= 1'b0;
      state_known_q <= 1'b0;
      word_err_q    <= 1'b0;
    end else begin
      state_valid_q <= 1'b0;
      word_err_q    <= 1'b0;
      if (frame_err_q) begin
        buf_q <= '0;
        len_q <= '0;
      end else if (byte_valid_q) begin
        if (is_space) begin
          if (discard_q) begin
            discard_q <= 1'b0;
          end else if (match) begin
            light_q       <= match_code;
            state_valid_q <= 1'b1;
            state_known_q <= 1'b1;
          end else begin
            word_err_q <= 1'b1;
          end
          buf_q <= '0;
          len_q <= '0;
        end else if (!discard_q) begin
          if (int'(len_q) == MAX_WORD - 1) begin
            word_err_q <= 1'b1;
            discard_q  <= 1'b1;
          end else begin
            buf_q <= {buf_q[71:0], byte_data_q};
            len_q <= len_q + LW'(1);
          end
        end
      end
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frame_err   = frame_err_q;
  assign light_state = light_q;
  assign state_valid = state_valid_q;
  assign state_known = state_known_q;
  assign word_err    = word_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_light_uart_rx.sv
// Directed-vector bench for traffic_light_uart_rx with a queue-based
// scoreboard fed by the stimulus and drained by an output monitor.
module tb_traffic_light_uart_rx;

  localparam int CPB = 105;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [1:0] light_state;
  logic       state_valid;
  logic       state_known;
  logic       frame_err;
  logic       word_err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte_q[$];
  logic [1:0] exp_state_q[$];
  logic       exp_werr_q[$];
  logic       exp_ferr_q[$];

  traffic_light_uart_rx #(.CLKS_PER_BIT(CPB), .MAX_WORD(11)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .light_state(light_state), .state_valid(state_valid),
    .state_known(state_known), .frame_err(frame_err),
    .word_err(word_err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (byte_valid) begin
      checks++;
      if (exp_byte_q.size() == 0) begin
        errors++;
        $display("FAIL byte_valid unexpected got %02h", byte_data);
      end else begin
        logic [7:0] e;
        e = exp_byte_q.pop_front();
        if (byte_data !== e) begin
          errors++;
          $display("FAIL byte_data got %02h exp %02h", byte_data, e);
        end
      end
    end
    if (state_valid) begin
      checks++;
      if (exp_state_q.size() == 0) begin
        errors++;
        $display("FAIL state_valid unexpected got %b", light_state);
      end else begin
        logic [1:0] s;
        s = exp_state_q.pop_front();
        if (light_state !== s) begin
          errors++;
          $display("FAIL light_state got %b exp %b", light_state, s);
        end
      end
    end
    if (word_err) begin
      checks++;
      if (exp_werr_q.size() == 0) begin
        errors++;
        $display("FAIL word_err unexpected got 1 exp 0");
      end else begin
        void'(exp_werr_q.pop_front());
      end
    end
    if (frame_err) begin
      checks++;
      if (exp_ferr_q.size() == 0) begin
        errors++;
        $display("FAIL frame_err unexpected got 1 exp 0");
      end else begin
        void'(exp_ferr_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // driver tasks (rx changes on negedge)
  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    if (good_stop) exp_byte_q.push_back(b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    if (!good_stop) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic drain(input string tag);
    repeat (3 * CPB) @(negedge clk);
    check({tag, "_byte_q_empty"}, exp_byte_q.size(), 0);
    check({tag, "_state_q_empty"}, exp_state_q.size(), 0);
    check({tag, "_werr_q_empty"}, exp_werr_q.size(), 0);
    check({tag, "_ferr_q_empty"}, exp_ferr_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_light", light_state, 2'b10);
    check("rst_known", state_known, 0);
    check("rst_fsm", dbg_state, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    exp_state_q.push_back(2'b01);
    send_str("Yellow ");
    drain("yellow");
    check("yellow_light", light_state, 2'b01);
    check("yellow_known", state_known, 1);

    exp_state_q.push_back(2'b11);
    exp_state_q.push_back(2'b00);
    send_str("Pedestrian Green ");
    drain("ped_green");
    check("ped_green_light", light_state, 2'b00);

    // reset in the middle of 'e' (0x65): start bit + bits 1,0,1 then reset
    send_str("Gr");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB) @(negedge clk);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_byte_data", byte_data, 8'h00);
    check("midrst_light", light_state, 2'b10);
    check("midrst_known", state_known, 0);
    check("midrst_fsm", dbg_state, 0);
    check("midrst_byte_q_empty", exp_byte_q.size(), 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_state_q.push_back(2'b00);
    send_str("Green ");
    drain("post_rst");
    check("post_rst_light", light_state, 2'b00);
    check("post_rst_known", state_known, 1);

    // framing error discards 'G' and the partial "Ye"
    send_str("Ye");
    exp_ferr_q.push_back(1'b1);
    send_byte("G", 1'b0);
    exp_state_q.push_back(2'b10);
    send_str("Red ");
    drain("ferr");
    check("ferr_light", light_state, 2'b10);

    // short glitch on rx must not start a frame
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch_fsm_idle", dbg_state, 0);
    check("glitch_byte_q_empty", exp_byte_q.size(), 0);
    exp_state_q.push_back(2'b10);
    send_str("Red ");
    drain("glitch");
    check("glitch_light", light_state, 2'b10);

    exp_werr_q.push_back(1'b1);
    send_str("Blue ");
    exp_werr_q.push_back(1'b1);
    send_str("GreenGreenGr ");
    drain("werr");
    check("werr_light", light_state, 2'b10);

    exp_state_q.push_back(2'b01);
    send_str("Yellow ");
    drain("recover");
    check("recover_light", light_state, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
